dragon_hit_detector: RTL
========================

// Module: dragon_hit_detector
// PURPOSE
//  Per-frame shot-vs-dragon hit detector. It sits directly upstream of the dragon mover
//  and drives that block's shotDragonCollision input.
//  Counts overlapping pixels of the dragon and each of 3 shots during the raster scan.
//  Evaluates the counts at startOfFrame and emits a 1-clk registered hit mask.
//  Also tracks dragon hit count, a post-hit cooldown and dragon death.
// PARAMETERS
//  MIN_OVERLAP     4    overlapping pixels per shot per frame required to count as a hit
//  COOLDOWN_FRAMES 30   frames after a counted hit during which further hits are not counted
//  HITS_TO_KILL    3    counted hits that kill the dragon (range 1..15)
// PORTS
//  clk                    in   1   system clock
//  resetN                 in   1   asynchronous active-low reset
//  startOfFrame           in   1   1-clk pulse, start of each video frame
//  pause                  in   1   game paused (level)
//  newLevel               in   1   1-clk pulse: rearm the dragon, clear hitCount
//  dragonDrawingRequest   in   1   dragon pixel active at the current raster position
//  shotDrawingRequest     in   3   bit i = shot i pixel active at the current raster position
//  shotDragonCollision    out  3   bit i = shot i hit the dragon last frame (1-clk pulse)
//  scoreInc               out  1   1-clk pulse when a hit is counted
//  hitCount               out  4   counted hits since reset/newLevel
//  dragonKilled           out  1   level, high while in DEAD
// BEHAVIOUR
//  Reset: state=ARMED; overlap counters=0; cooldown=0.
//   Outputs after reset: shotDragonCollision=0, scoreInc=0, hitCount=0, dragonKilled=0.
//  Overlap counters: ovl[i] are 10 bits each, saturating at 1023.
//   +1 on each clk where dragonDrawingRequest && shotDrawingRequest[i] && !pause && !startOfFrame.
//  Evaluation: on startOfFrame, hitMask[i] = (ovl[i] >= MIN_OVERLAP). All ovl are cleared that same clk.
//   An overlap present in the startOfFrame cycle itself is discarded.
//  While pause=1: no accumulation, hitMask forced to 0, cooldown frozen, ovl still cleared at startOfFrame.
//  Output latency: shotDragonCollision <= hitMask is registered on the startOfFrame edge.
//   It is high for exactly the one following clk, then returns to 0.
//   The hit mask is reported in every state except DEAD, so shots are consumed even during cooldown.
//  FSM:
//   ARMED: on startOfFrame with hitMask!=0, one hit is counted regardless of popcount(hitMask).
//    Counting a hit means hitCount+1 and scoreInc pulsed together with shotDragonCollision.
//    If the new hitCount==HITS_TO_KILL -> DEAD. Otherwise -> COOLDOWN with cooldown=COOLDOWN_FRAMES.
//   COOLDOWN: on each startOfFrame with !pause, cooldown-1. When cooldown reaches 0 -> ARMED.
//    Hits during COOLDOWN are reported on shotDragonCollision but are not counted.
//    The frame in which cooldown reaches 0 is still not counted.
//   DEAD: dragonKilled=1; shotDragonCollision and scoreInc held 0; ovl ignored.
//  newLevel (any state): -> ARMED; hitCount=0; cooldown=0; ovl cleared.
//   If it coincides with startOfFrame, newLevel wins: evaluation is discarded and no outputs pulse.
//  COOLDOWN_FRAMES=0: a counted hit goes directly back to ARMED.
//  hitCount never exceeds HITS_TO_KILL (it is frozen in DEAD).
//  Reset mid-frame: all partial overlap counts are lost; no pulse follows.
// TESTING
//  1. Shot1 overlaps dragon for 5 clks, then startOfFrame.
//     -> next clk: shotDragonCollision=3'b010, scoreInc=1, hitCount=1; one clk later both are 0.
//  2. Shot0 overlaps for 3 clks (below MIN_OVERLAP=4), then startOfFrame.
//     -> shotDragonCollision=0, scoreInc=0, hitCount unchanged.
//  3. Shots 0 and 2 both overlap for 8 clks in the same frame.
//     -> mask 3'b101, hitCount+1 only. A new hit 10 frames later -> mask reported, scoreInc=0 (COOLDOWN).
//  4. Three counted hits spaced 31 frames apart -> dragonKilled=1, hitCount=3.
//     A 4th overlap -> no pulses. Then newLevel -> dragonKilled=0, hitCount=0.
//  5. pause=1 with 20 overlap clks, then startOfFrame -> no pulse.
//     Cooldown value is unchanged across 5 paused frames.
//  6. newLevel coincident with startOfFrame after 10 overlap clks -> no pulse, state ARMED.
//     Separately, resetN asserted mid-frame -> all outputs 0 at once.

Source files
------------

// File: rtl/dragon_hit_detector_if.sv
// dragon_hit_detector_if: raster-scan inputs and hit/score outputs of the dragon hit detector
interface dragon_hit_detector_if;
    logic       startOfFrame;
    logic       pause;
    logic       newLevel;
    logic       dragonDrawingRequest;
    logic [2:0] shotDrawingRequest;
    logic [2:0] shotDragonCollision;
    logic       scoreInc;
    logic [3:0] hitCount;
    logic       dragonKilled;
    modport master (
        output startOfFrame, pause, newLevel, dragonDrawingRequest, shotDrawingRequest,
        input  shotDragonCollision, scoreInc, hitCount, dragonKilled
    );
    modport slave (
        input  startOfFrame, pause, newLevel, dragonDrawingRequest, shotDrawingRequest,
        output shotDragonCollision, scoreInc, hitCount, dragonKilled
    );
endinterface

// File: rtl/dragon_hit_detector.sv
// dragon_hit_detector: per-frame shot/dragon pixel overlap counting, hit pulses, cooldown and kill tracking
module dragon_hit_detector #(
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int HITS_TO_KILL    = 3
) (
    input logic                  clk,
    input logic                  resetN,
    dragon_hit_detector_if.slave bus
);
    localparam int              CW      = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [9:0]      MIN_OVL = 10'(MIN_OVERLAP);
    localparam logic [CW-1:0]   CD_LOAD = CW'(COOLDOWN_FRAMES);
    localparam logic [3:0]      KILL    = 4'(HITS_TO_KILL);
    typedef enum logic [1:0] {ARMED, COOLDOWN, DEAD} state_t;
    state_t        state;
    logic [9:0]    ovl [3];
    logic [CW-1:0] cooldown;
    logic [2:0]    hit_mask;
    logic [3:0]    next_count;
    always_comb begin
        for (int i = 0; i < 3; i++) hit_mask[i] = !bus.pause && ovl[i] >= MIN_OVL;
    end
    assign next_count = bus.hitCount + 4'd1;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state                   <= ARMED;
            cooldown                <= '0;
            ovl                     <= '{default: '0};
            bus.shotDragonCollision <= '0;
            bus.scoreInc            <= 1'b0;
            bus.hitCount            <= '0;
            bus.dragonKilled        <= 1'b0;
        end else if (bus.newLevel) begin
            state                   <= ARMED;
            cooldown                <= '0;
            ovl                     <= '{default: '0};
            bus.shotDragonCollision <= '0;
            bus.scoreInc            <= 1'b0;
            bus.hitCount            <= '0;
            bus.dragonKilled        <= 1'b0;
        end else begin
            bus.shotDragonCollision <= '0;
            bus.scoreInc            <= 1'b0;
            if (bus.startOfFrame) begin
                // overlap seen during the startOfFrame cycle itself is dropped with the clear
                ovl <= '{default: '0};
                if (state != DEAD) bus.shotDragonCollision <= hit_mask;
                if (state == ARMED && hit_mask != 3'b000) begin
                    bus.scoreInc <= 1'b1;
                    bus.hitCount <= next_count;
                    cooldown     <= CD_LOAD;
                    if (next_count == KILL) begin
                        state            <= DEAD;
                        bus.dragonKilled <= 1'b1;
                    end else begin
                        state <= (CD_LOAD == '0) ? ARMED : COOLDOWN;
                    end
                end else if (state == COOLDOWN && !bus.pause) begin
                    cooldown <= cooldown - 1'b1;
                    if (cooldown == CW'(1)) state <= ARMED;
                end
            end else begin
                for (int i = 0; i < 3; i++)
                    if (bus.dragonDrawingRequest && bus.shotDrawingRequest[i] && !bus.pause && ovl[i] != '1)
                        ovl[i] <= ovl[i] + 10'd1;
            end
        end
    end
endmodule
